msdf_otf_converter: RTL and testbench

- On-the-fly converter (OTFC) at the output end of the MSDF serial-serial adder datapath.
- Consumes the most-significant-digit-first radix-2 signed-digit stream (Zj qualified by ready_Zj) and rebuilds the conventional two's-complement word digit by digit, with no carry-propagate adder.
- Presents each completed word on a valid/ready output port with a one-entry holding register, so back-to-back words stream without bubbles.

---
 rtl/msdf_otf_converter_if.sv | 23 ++
 rtl/msdf_otf_converter.sv | 121 ++++++++++++
 tb/tb_msdf_otf_converter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/msdf_otf_converter_if.sv
// Handshake bundle between the MSDF adder digit stream and the on-the-fly
// converter's word output. The master drives digits and consumes words.
interface msdf_otf_converter_if #(
  parameter int N = 9
);
  logic [1:0] in_digit;
  logic       in_valid;
  logic       in_ready;
  logic [N:0] out_result;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  modport master (
    output in_digit, in_valid, out_ready,
    input  in_ready, out_result, out_valid, err
  );

  modport slave (
    input  in_digit, in_valid, out_ready,
    output in_ready, out_result, out_valid, err
  );
endinterface

// File: rtl/msdf_otf_converter.sv
// On-the-fly converter: rebuilds a two's-complement word from an MSD-first
// radix-2 signed-digit stream using the Q/QM pair (QM = Q - 1), so no carry
// propagation is needed. Completed words sit in a one-entry output register.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | output register free
// FULL  | output register holds a word
// STALL | FULL and the final digit of the next word is pending; in_ready
//       | drops unless the held word is consumed this cycle
module msdf_otf_converter #(
  parameter int N = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  msdf_otf_converter_if.slave    bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    STALL
  } state_t;

  state_t        state, state_nxt;
  logic [N:0]    q, qm, q_nxt, qm_nxt;
  logic [N:0]    result;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q;
  logic          d_pos, d_neg, d_bad;
  logic          accept, last, consume, drop, out_valid_nxt;

  assign bus.in_ready   = !(state == STALL && !bus.out_ready);
  assign bus.out_valid  = (state != EMPTY);
  assign bus.out_result = result;
  assign bus.err        = err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign last    = accept && (cnt == CNT_LAST);
  assign consume = bus.out_valid && bus.out_ready;
  assign drop    = bus.in_valid && !bus.in_ready;

  // Decode the digit and form the next Q/QM; the illegal code 11 converts as 0.
  always_comb begin
    d_pos  = (bus.in_digit == 2'b10);
    d_neg  = (bus.in_digit == 2'b01);
    d_bad  = (bus.in_digit == 2'b11);
    q_nxt  = {q[N-1:0], 1'b0};
    qm_nxt = {qm[N-1:0], 1'b1};
    if (d_pos) begin
      q_nxt  = {q[N-1:0], 1'b1};
      qm_nxt = {q[N-1:0], 1'b0};
    end else if (d_neg) begin
      q_nxt  = {qm[N-1:0], 1'b1};
      qm_nxt = {qm[N-1:0], 1'b0};
    end
  end

  // Next digit count and output-register state.
  always_comb begin
    cnt_nxt       = cnt;
    out_valid_nxt = last || (bus.out_valid && !consume);
    state_nxt     = EMPTY;
    if (last) begin
      cnt_nxt = '0;
    end else if (accept) begin
      cnt_nxt = cnt + CW'(1);
    end
    if (out_valid_nxt) begin
      state_nxt = (cnt_nxt == CNT_LAST) ? STALL : FULL;
    end
    if (clear) begin
      cnt_nxt   = '0;
      state_nxt = EMPTY;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Conversion datapath: Q/QM shift, digit count, word capture, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      qm     <= '1;
      cnt    <= '0;
      result <= '0;
      err_q  <= 1'b0;
    end else if (clear) begin
      q      <= '0;
      qm     <= '1;
      cnt    <= '0;
      result <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (last) begin
        result <= q_nxt;
        q      <= '0;
        qm     <= '1;
      end else if (accept) begin
        q  <= q_nxt;
        qm <= qm_nxt;
      end
      if ((accept && d_bad) || drop) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Directed bench for the on-the-fly converter: a table of single words plus
// hand-written sequences for streaming, backpressure, reset and clear.
module tb_msdf_otf_converter;

  localparam int N = 9;

  logic clk;
  logic rst;
  logic clear;
  int   checks;
  int   errors;

  msdf_otf_converter_if #(.N(N)) bus ();

  msdf_otf_converter #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] digits;
    logic [9:0]  exp_result;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_digits(input logic [17:0] w, input int count);
    for (int i = 0; i < count; i++) begin
      bus.in_digit = w[17-2*i -: 2];
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{18'h2AAAA, 10'h1FF, 1'b0};
    vecs[1] = '{18'h15555, 10'h201, 1'b0};
    vecs[2] = '{18'h1AAAA, 10'h3FF, 1'b0};
    vecs[3] = '{18'h24000, 10'h080, 1'b0};
    vecs[4] = '{18'h2BAAA, 10'h1BF, 1'b1};
    vecs[5] = '{18'h21206, 10'h0CF, 1'b0};

    rst = 1'b1;
    clear = 1'b0;
    bus.in_digit = 2'b00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_result", {22'd0, bus.out_result}, 32'd0);
    check("reset err", {31'd0, bus.err}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // single words from the table
    for (int v = 0; v < 6; v++) begin
      do_clear();
      bus.out_ready = 1'b1;
      send_digits(vecs[v].digits, N);
      check($sformatf("vec%0d out_valid", v), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("vec%0d out_result", v), {22'd0, bus.out_result}, {22'd0, vecs[v].exp_result});
      check($sformatf("vec%0d err", v), {31'd0, bus.err}, {31'd0, vecs[v].exp_err});
      tick();
      check($sformatf("vec%0d out_valid drop", v), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("vec%0d err sticky", v), {31'd0, bus.err}, {31'd0, vecs[v].exp_err});
    end
    do_clear();
    check("clear err", {31'd0, bus.err}, 32'd0);

    // two words back-to-back, no input gap
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      bus.in_digit = (i < N) ? 2'b10 : 2'b01;
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("b2b in_ready %0d", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
      check($sformatf("b2b out_valid %0d", i), {31'd0, bus.out_valid},
            (i == N - 1 || i == 2 * N - 1) ? 32'd1 : 32'd0);
      if (i == N - 1)
        check("b2b word1", {22'd0, bus.out_result}, 32'h1FF);
      if (i == 2 * N - 1)
        check("b2b word2", {22'd0, bus.out_result}, 32'h201);
    end
    bus.in_valid = 1'b0;
    tick();
    check("b2b idle", {31'd0, bus.out_valid}, 32'd0);

    // backpressure: word 1 held, word 2 stalls on its final digit
    do_clear();
    bus.out_ready = 1'b0;
    send_digits(18'h2AAAA, N);
    check("bp word1 valid", {31'd0, bus.out_valid}, 32'd1);
    send_digits(18'h15555, N - 1);
    check("bp in_ready low", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("bp hold valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp hold result", {22'd0, bus.out_result}, 32'h1FF);
    check("bp no err yet", {31'd0, bus.err}, 32'd0);
    bus.in_digit = 2'b10;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp drop err", {31'd0, bus.err}, 32'd1);
    check("bp drop held", {22'd0, bus.out_result}, 32'h1FF);
    bus.out_ready = 1'b1;
    #1;
    check("bp in_ready release", {31'd0, bus.in_ready}, 32'd1);
    bus.in_digit = 2'b01;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp word2 valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp word2 result", {22'd0, bus.out_result}, 32'h201);
    tick();
    check("bp word2 consumed", {31'd0, bus.out_valid}, 32'd0);
    check("bp err sticky", {31'd0, bus.err}, 32'd1);

    // async reset mid-word
    do_clear();
    send_digits(18'h2AAAA, 4);
    #3;
    rst = 1'b1;
    #1;
    check("rst async valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      bus.in_digit = 2'b00;
      bus.in_valid = 1'b1;
      tick();
      check($sformatf("rst abort no valid %0d", i), {31'd0, bus.out_valid}, 32'd0);
    end
    send_digits(18'h00000, 1);
    check("rst fresh valid", {31'd0, bus.out_valid}, 32'd1);
    check("rst fresh result", {22'd0, bus.out_result}, 32'h000);
    tick();

    // clear mid-word, with an illegal digit already seen and a digit offered
    send_digits(18'h3AAAA, 4);
    check("clr err set", {31'd0, bus.err}, 32'd1);
    bus.in_digit = 2'b10;
    bus.in_valid = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr err cleared", {31'd0, bus.err}, 32'd0);
    for (int i = 0; i < N - 1; i++) begin
      bus.in_digit = 2'b00;
      bus.in_valid = 1'b1;
      tick();
      check($sformatf("clr abort no valid %0d", i), {31'd0, bus.out_valid}, 32'd0);
    end
    send_digits(18'h00000, 1);
    check("clr fresh valid", {31'd0, bus.out_valid}, 32'd1);
    check("clr fresh result", {22'd0, bus.out_result}, 32'h000);
    check("clr fresh err", {31'd0, bus.err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
